// File: rtl/game_pkg.sv
// game_pkg: shared score widths, BCD digit type and converter state encoding
package game_pkg;
    localparam int SCORE_W      = 17;
    localparam int MAX_SCORE    = 114000;
    localparam int SCORE_DIGITS = 6;
    typedef logic [3:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble add-3 correction for one BCD digit
module bcd_digit_adj
    import game_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);
    assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: serial double-dabble of the score into packed BCD, clamping underflowed scores to zero
module score_bcd_converter #(
    parameter int BIN_W     = game_pkg::SCORE_W,
    parameter int DIGITS    = game_pkg::SCORE_DIGITS,
    parameter int MAX_SCORE = game_pkg::MAX_SCORE,
    parameter bit AUTO      = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                clamp
);
    import game_pkg::*;
    localparam int SW = 4 * DIGITS;
    localparam int CW = $clog2(BIN_W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIN_W - 1);
    localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_SCORE);

    // The scratch register must hold every legal score without overflowing its top digit
    if (MAX_SCORE >= 10 ** DIGITS) begin : g_width_check
        $error("score_bcd_converter: MAX_SCORE does not fit in DIGITS BCD digits");
    end

    state_t           state, state_nx;
    logic [BIN_W-1:0] operand, last;
    logic [SW-1:0]    scratch, adj;
    logic [CW-1:0]    cnt;
    logic             clamp_pend;
    logic             over, req;

    assign over = bin_in > MAX_B;
    assign req  = start | (AUTO && bin_in != last);
    assign busy = state != IDLE;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit   (scratch[4*i +: 4]),
            .adjusted(adj[4*i +: 4])
        );
    end

    // Next state: IDLE waits for a request, SHIFT runs BIN_W shifts, DONE publishes for one edge
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE)  ? (req ? SHIFT : IDLE) :
                   (state == SHIFT) ? ((cnt == LAST_CNT) ? DONE : SHIFT) : IDLE;
    end

    // Datapath: latch operand on request, shift-add-3 per bit, publish result and clamp flag together
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            operand    <= '0;
            last       <= '0;
            scratch    <= '0;
            cnt        <= '0;
            clamp_pend <= 1'b0;
            bcd_out    <= '0;
            clamp      <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == DONE;
            if (state == IDLE && req) begin
                operand    <= over ? '0 : bin_in;
                clamp_pend <= over;
                last       <= bin_in;
                scratch    <= '0;
                cnt        <= '0;
            end
            if (state == SHIFT) begin
                scratch <= {adj[SW-2:0], operand[BIN_W-1]};
                operand <= {operand[BIN_W-2:0], 1'b0};
                cnt     <= cnt + CW'(1);
            end
            if (state == DONE) begin
                bcd_out <= scratch;
                clamp   <= clamp_pend;
            end
        end
    end
endmodule
